// File: rtl/conv_pkg.sv
// Shared state encoding and elaboration-time helpers for the conv scan controller.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } scan_state_t;

    localparam int RLT_W = 4;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int res_dim(input int img_dim, input int k_dim,
                                   input int pad, input int strd);
        return (img_dim - k_dim + 2 * pad) / strd + 1;
    endfunction

endpackage

// File: rtl/conv_lat_dly.sv
// Shift register matching the MAC pipeline depth; carries the window-start flag
// and window index alongside the data so they leave the MAC together.
module conv_lat_dly #(
    parameter int depth = 1,
    parameter int width = 1
) (
    input  logic             clk_en,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_sr [depth];

    always_ff @(posedge clk_en) begin
        if (!rst_n || i_clr) begin
            for (int i = 0; i < depth; i++) r_sr[i] <= '0;
        end else if (i_en) begin
            r_sr[0] <= i_d;
            for (int i = 1; i < depth; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[depth-1];

endmodule

// File: rtl/conv_scan_ctrl.sv
// Walks the conv window over a flattened image and streams one pixel/weight pair
// per cycle to the MAC, with reload, write-suppress and result-address strobes.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int weight_width  = 2,
    parameter int weight_height = 2,
    parameter int img_width     = 4,
    parameter int img_height    = 4,
    parameter int padding       = 0,
    parameter int stride        = 1,
    parameter int bitwidth      = 3,
    parameter int mac_lat       = 1
) (
    input  logic                                       clk_en,
    input  logic                                       rst_n,
    input  logic                                       i_start,
    input  logic [img_width*img_height*bitwidth-1:0]   i_img,
    input  logic [weight_width*weight_height*bitwidth-1:0] i_wei,
    output logic                                       o_conv_on,
    output logic                                       o_chge_rlt,
    output logic                                       o_chge_rlt_q,
    output logic                                       o_srh_fin,
    output logic [3:0]                                 o_rlt_l,
    output logic [3:0]                                 o_rlt_c,
    output logic [bitwidth-1:0]                        o_img_cal,
    output logic [bitwidth-1:0]                        o_wei_cal,
    output logic                                       o_busy,
    output logic                                       o_done
);

    localparam int RES_W = res_dim(img_width, weight_width, padding, stride);
    localparam int RES_H = res_dim(img_height, weight_height, padding, stride);
    localparam int KCW   = clog2w(weight_width);
    localparam int KRW   = clog2w(weight_height);
    localparam int WCW   = clog2w(RES_W);
    localparam int WRW   = clog2w(RES_H);
    localparam int DRW   = clog2w(mac_lat);
    localparam int DLY_W = 1 + WRW + WCW;

    localparam logic [KCW-1:0] KC_LAST  = KCW'(weight_width - 1);
    localparam logic [KRW-1:0] KR_LAST  = KRW'(weight_height - 1);
    localparam logic [WCW-1:0] WC_LAST  = WCW'(RES_W - 1);
    localparam logic [WRW-1:0] WR_LAST  = WRW'(RES_H - 1);
    localparam logic [DRW-1:0] DRN_LAST = DRW'(mac_lat - 1);

    scan_state_t         r_state;
    logic [KCW-1:0]      r_kc;
    logic [KRW-1:0]      r_kr;
    logic [WCW-1:0]      r_wc;
    logic [WRW-1:0]      r_wr;
    logic [DRW-1:0]      r_drn;
    logic                r_conv_on;
    logic                r_chge_rlt;
    logic                r_srh_fin;
    logic                r_busy;
    logic                r_done;
    logic [bitwidth-1:0] r_img_cal;
    logic [bitwidth-1:0] r_wei_cal;

    logic [KCW-1:0]      w_kc_nxt;
    logic [KRW-1:0]      w_kr_nxt;
    logic [WCW-1:0]      w_wc_nxt;
    logic [WRW-1:0]      w_wr_nxt;
    logic                w_last_tap;
    logic                w_last_win;
    logic                w_start_acc;
    int                  w_tap_r;
    int                  w_tap_c;
    logic [bitwidth-1:0] w_pix;
    logic [bitwidth-1:0] w_wgt;
    logic [DLY_W-1:0]    w_dly_d;
    logic [DLY_W-1:0]    w_dly_q;

    // Counters always name the tap currently on the outputs; the next-tap values
    // feed the output registers so pixel, weight and strobes stay aligned.
    always_comb begin
        w_kc_nxt   = r_kc;
        w_kr_nxt   = r_kr;
        w_wc_nxt   = r_wc;
        w_wr_nxt   = r_wr;
        w_last_tap = (r_kc == KC_LAST) && (r_kr == KR_LAST);
        w_last_win = (r_wc == WC_LAST) && (r_wr == WR_LAST);
        case (r_state)
            ST_RUN: begin
                if (!(w_last_tap && w_last_win)) begin
                    if (r_kc != KC_LAST) begin
                        w_kc_nxt = r_kc + KCW'(1);
                    end else begin
                        w_kc_nxt = '0;
                        if (r_kr != KR_LAST) begin
                            w_kr_nxt = r_kr + KRW'(1);
                        end else begin
                            w_kr_nxt = '0;
                            if (r_wc != WC_LAST) begin
                                w_wc_nxt = r_wc + WCW'(1);
                            end else begin
                                w_wc_nxt = '0;
                                w_wr_nxt = r_wr + WRW'(1);
                            end
                        end
                    end
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                w_kc_nxt = '0;
                w_kr_nxt = '0;
                w_wc_nxt = '0;
                w_wr_nxt = '0;
            end
        endcase
    end

    // Padded taps land outside the image and read as zero.
    always_comb begin
        w_tap_r = int'(w_wr_nxt) * stride + int'(w_kr_nxt) - padding;
        w_tap_c = int'(w_wc_nxt) * stride + int'(w_kc_nxt) - padding;
        w_pix   = '0;
        if (w_tap_r >= 0 && w_tap_r < img_height && w_tap_c >= 0 && w_tap_c < img_width)
            w_pix = bitwidth'(i_img >> ((w_tap_r * img_width + w_tap_c) * bitwidth));
        w_wgt = bitwidth'(i_wei >> ((int'(w_kr_nxt) * weight_width + int'(w_kc_nxt)) * bitwidth));
    end

    assign w_start_acc = (r_state == ST_IDLE) && i_start;

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_kc       <= '0;
            r_kr       <= '0;
            r_wc       <= '0;
            r_wr       <= '0;
            r_drn      <= '0;
            r_conv_on  <= 1'b0;
            r_chge_rlt <= 1'b0;
            r_srh_fin  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_img_cal  <= '0;
            r_wei_cal  <= '0;
        end else begin
            r_kc <= w_kc_nxt;
            r_kr <= w_kr_nxt;
            r_wc <= w_wc_nxt;
            r_wr <= w_wr_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_conv_on  <= 1'b1;
                        r_chge_rlt <= 1'b1;
                        r_busy     <= 1'b1;
                        r_img_cal  <= w_pix;
                        r_wei_cal  <= w_wgt;
                    end
                end
                ST_RUN: begin
                    if (w_last_tap && w_last_win) begin
                        r_state    <= ST_DRAIN;
                        r_drn      <= '0;
                        r_chge_rlt <= 1'b0;
                        r_img_cal  <= '0;
                        r_wei_cal  <= '0;
                    end else begin
                        r_chge_rlt <= (w_kr_nxt == '0) && (w_kc_nxt == '0);
                        r_img_cal  <= w_pix;
                        r_wei_cal  <= w_wgt;
                    end
                end
                ST_DRAIN: begin
                    if (r_drn == DRN_LAST) begin
                        r_state   <= ST_FIN;
                        r_conv_on <= 1'b0;
                        r_busy    <= 1'b0;
                        r_srh_fin <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_drn <= r_drn + DRW'(1);
                    end
                end
                ST_FIN: begin
                    r_state   <= ST_IDLE;
                    r_srh_fin <= 1'b0;
                    r_done    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shifting only while the MAC is enabled leaves the last result address parked after the scan.
    assign w_dly_d = {r_chge_rlt, r_wr, r_wc};

    conv_lat_dly #(
        .depth (mac_lat),
        .width (DLY_W)
    ) u_lat_dly (
        .clk_en (clk_en),
        .rst_n  (rst_n),
        .i_clr  (w_start_acc),
        .i_en   (r_conv_on),
        .i_d    (w_dly_d),
        .o_q    (w_dly_q)
    );

    assign o_conv_on    = r_conv_on;
    assign o_chge_rlt   = r_chge_rlt;
    assign o_chge_rlt_q = w_dly_q[DLY_W-1];
    assign o_srh_fin    = r_srh_fin;
    assign o_rlt_l      = RLT_W'(w_dly_q[WCW +: WRW]);
    assign o_rlt_c      = RLT_W'(w_dly_q[0 +: WCW]);
    assign o_img_cal    = r_img_cal;
    assign o_wei_cal    = r_wei_cal;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench: four controller instances (default, stride 2, padding 1, mac_lat 3),
// pixels 1..16 row-major and weights 1..4, 5-bit data so pixel 16 is representable.
module tb_conv_scan_ctrl;

    typedef struct packed {
        logic       chge;
        logic [4:0] img;
        logic [4:0] wei;
        logic       chgeQ;
        logic [3:0] rl;
        logic [3:0] rc;
    } obs_t;

    typedef struct {
        int chge;
        int img;
        int wei;
        int wr;
        int wc;
    } tap_t;

    logic            clk_en = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      sel;
    logic [79:0]     img;
    logic [19:0]     wei;
    logic [3:0]      convOn, chge, chgeQ, srhFin, busy, done;
    logic [3:0][3:0] rltL, rltC;
    logic [3:0][4:0] imgCal, weiCal;

    logic       mConvOn, mChge, mChgeQ, mFin, mBusy, mDone;
    logic [3:0] mRltL, mRltC;
    logic [4:0] mImg, mWei;

    obs_t sbq[$];
    int   cap[$];
    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    int   startCyc, doneCyc, doneCnt, finCnt, onCnt;
    bit   startSeen;
    bit   sbEn = 1'b0;
    obs_t got, expv;

    always #5 clk_en = ~clk_en;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        conv_scan_ctrl #(
            .weight_width  (2),
            .weight_height (2),
            .img_width     (4),
            .img_height    (4),
            .padding       (g == 2 ? 1 : 0),
            .stride        (g == 1 ? 2 : 1),
            .bitwidth      (5),
            .mac_lat       (g == 3 ? 3 : 1)
        ) u_dut (
            .clk_en       (clk_en),
            .rst_n        (rst_n),
            .i_start      (start && (sel == 2'(g))),
            .i_img        (img),
            .i_wei        (wei),
            .o_conv_on    (convOn[g]),
            .o_chge_rlt   (chge[g]),
            .o_chge_rlt_q (chgeQ[g]),
            .o_srh_fin    (srhFin[g]),
            .o_rlt_l      (rltL[g]),
            .o_rlt_c      (rltC[g]),
            .o_img_cal    (imgCal[g]),
            .o_wei_cal    (weiCal[g]),
            .o_busy       (busy[g]),
            .o_done       (done[g])
        );
    end

    always_comb begin
        mConvOn = convOn[sel];
        mChge   = chge[sel];
        mChgeQ  = chgeQ[sel];
        mFin    = srhFin[sel];
        mBusy   = busy[sel];
        mDone   = done[sel];
        mRltL   = rltL[sel];
        mRltC   = rltC[sel];
        mImg    = imgCal[sel];
        mWei    = weiCal[sel];
    end

    // Monitor: every MAC-enabled cycle consumes one expected tap from the scoreboard.
    always @(negedge clk_en) begin
        ncyc++;
        if (sbEn) begin
            if (start && !startSeen) begin
                startSeen = 1'b1;
                startCyc  = ncyc;
            end
            if (mDone) begin
                doneCnt++;
                doneCyc = ncyc;
            end
            if (mFin) finCnt++;
            if (mConvOn) begin
                got = '{chge: mChge, img: mImg, wei: mWei, chgeQ: mChgeQ, rl: mRltL, rc: mRltC};
                cap.push_back(int'(mImg));
                onCnt++;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL extra_tap sel=%0d got chge=%0d img=%0d wei=%0d chq=%0d rlt=(%0d,%0d) expected no tap",
                             sel, got.chge, got.img, got.wei, got.chgeQ, got.rl, got.rc);
                end else begin
                    expv = sbq.pop_front();
                    if (got !== expv) begin
                        failures++;
                        $display("[TB] FAIL tap%0d sel=%0d got chge=%0d img=%0d wei=%0d chq=%0d rlt=(%0d,%0d) expected chge=%0d img=%0d wei=%0d chq=%0d rlt=(%0d,%0d)",
                                 onCnt - 1, sel, got.chge, got.img, got.wei, got.chgeQ, got.rl, got.rc,
                                 expv.chge, expv.img, expv.wei, expv.chgeQ, expv.rl, expv.rc);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int gotV, input int expV);
        checks++;
        if (gotV != expV) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, gotV, expV);
        end
    endtask

    task automatic checkCap(input string name, input int idx, input int expV);
        if (idx < cap.size()) checkOutput(name, cap[idx], expV);
        else checkOutput(name, -1, expV);
    endtask

    function automatic int strideOf(input int s); return (s == 1) ? 2 : 1; endfunction
    function automatic int padOf(input int s);    return (s == 2) ? 1 : 0; endfunction
    function automatic int latOf(input int s);    return (s == 3) ? 3 : 1; endfunction

    // Reference walk of the kernel over the image; results leave the MAC lat cycles later.
    task automatic buildExpected(input int s, output int nTot, output int rw, output int rh);
        tap_t taps[$];
        tap_t t;
        obs_t e;
        int st, pd, lt, r, c;
        st = strideOf(s);
        pd = padOf(s);
        lt = latOf(s);
        rw = (4 - 2 + 2 * pd) / st + 1;
        rh = rw;
        for (int wr = 0; wr < rh; wr++)
            for (int wc = 0; wc < rw; wc++)
                for (int kr = 0; kr < 2; kr++)
                    for (int kc = 0; kc < 2; kc++) begin
                        r      = wr * st + kr - pd;
                        c      = wc * st + kc - pd;
                        t.chge = (kr == 0 && kc == 0) ? 1 : 0;
                        t.img  = (r < 0 || r > 3 || c < 0 || c > 3) ? 0 : r * 4 + c + 1;
                        t.wei  = kr * 2 + kc + 1;
                        t.wr   = wr;
                        t.wc   = wc;
                        taps.push_back(t);
                    end
        for (int d = 0; d < lt; d++) taps.push_back('{0, 0, 0, rh - 1, rw - 1});
        nTot = taps.size();
        for (int i = 0; i < nTot; i++) begin
            e = '0;
            e.chge = taps[i].chge[0];
            e.img  = 5'(taps[i].img);
            e.wei  = 5'(taps[i].wei);
            if (i >= lt) begin
                e.chgeQ = taps[i-lt].chge[0];
                e.rl    = 4'(taps[i-lt].wr);
                e.rc    = 4'(taps[i-lt].wc);
            end
            sbq.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input bit midPulse, input bit finPulse);
        int nTot, rw, rh, k;
        sel       = s;
        sbq.delete();
        cap.delete();
        startSeen = 1'b0;
        doneCnt   = 0;
        finCnt    = 0;
        onCnt     = 0;
        startCyc  = 0;
        doneCyc   = 0;
        sbEn      = 1'b1;
        buildExpected(int'(s), nTot, rw, rh);
        @(posedge clk_en); #1 start = 1'b1;
        @(posedge clk_en); #1 start = 1'b0;
        k = 0;
        while (!mDone && k < 300) begin
            start = midPulse && (k == 10);
            @(posedge clk_en); #1;
            k++;
        end
        start = 1'b0;
        checkOutput("done_reached", int'(mDone), 1);
        checkOutput("fin_srh_fin", int'(mFin), 1);
        checkOutput("fin_busy", int'(mBusy), 0);
        checkOutput("fin_conv_on", int'(mConvOn), 0);
        checkOutput("fin_rlt_l", int'(mRltL), rh - 1);
        checkOutput("fin_rlt_c", int'(mRltC), rw - 1);
        if (finPulse) begin
            start = 1'b1;
            @(posedge clk_en); #1 start = 1'b0;
        end
        repeat (6) @(posedge clk_en);
        #1;
        checkOutput("done_pulses", doneCnt, 1);
        checkOutput("srh_fin_pulses", finCnt, 1);
        checkOutput("conv_on_cycles", onCnt, nTot);
        checkOutput("sb_leftover", sbq.size(), 0);
        checkOutput("latency", doneCyc - startCyc, rw * rh * 4 + latOf(int'(s)) + 1);
        checkOutput("idle_rlt_l_held", int'(mRltL), rh - 1);
        checkOutput("idle_rlt_c_held", int'(mRltC), rw - 1);
        checkOutput("idle_busy", int'(mBusy), 0);
        sbEn = 1'b0;
    endtask

    task automatic handChecks(input int s);
        case (s)
            0: begin
                checkOutput("s0_on_cycles", onCnt, 37);
                checkOutput("s0_latency", doneCyc - startCyc, 38);
                checkCap("s0_w0_t0", 0, 1);
                checkCap("s0_w0_t1", 1, 2);
                checkCap("s0_w0_t2", 2, 5);
                checkCap("s0_w0_t3", 3, 6);
                checkCap("s0_w8_t3", 35, 16);
                checkCap("s0_drain", 36, 0);
            end
            1: begin
                checkOutput("s1_on_cycles", onCnt, 17);
                checkCap("s1_w1_t0", 4, 3);
                checkCap("s1_w1_t1", 5, 4);
                checkCap("s1_w1_t2", 6, 7);
                checkCap("s1_w1_t3", 7, 8);
            end
            2: begin
                checkOutput("s2_on_cycles", onCnt, 101);
                checkCap("s2_w00_t0", 0, 0);
                checkCap("s2_w00_t1", 1, 0);
                checkCap("s2_w00_t2", 2, 0);
                checkCap("s2_w00_t3", 3, 1);
                checkCap("s2_w44_t0", 96, 16);
                checkCap("s2_w44_t1", 97, 0);
                checkCap("s2_w44_t2", 98, 0);
                checkCap("s2_w44_t3", 99, 0);
            end
            default: begin
                checkOutput("s3_on_cycles", onCnt, 39);
                checkOutput("s3_latency", doneCyc - startCyc, 40);
                checkCap("s3_drain0", 36, 0);
                checkCap("s3_drain2", 38, 0);
            end
        endcase
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_conv_on"}, int'(mConvOn), 0);
        checkOutput({tag, "_chge_rlt"}, int'(mChge), 0);
        checkOutput({tag, "_chge_rlt_q"}, int'(mChgeQ), 0);
        checkOutput({tag, "_srh_fin"}, int'(mFin), 0);
        checkOutput({tag, "_rlt_l"}, int'(mRltL), 0);
        checkOutput({tag, "_rlt_c"}, int'(mRltC), 0);
        checkOutput({tag, "_img_cal"}, int'(mImg), 0);
        checkOutput({tag, "_wei_cal"}, int'(mWei), 0);
        checkOutput({tag, "_busy"}, int'(mBusy), 0);
        checkOutput({tag, "_done"}, int'(mDone), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 2'd0;
        for (int i = 0; i < 16; i++) img[i*5 +: 5] = 5'(i + 1);
        for (int i = 0; i < 4; i++)  wei[i*5 +: 5] = 5'(i + 1);
        repeat (3) @(posedge clk_en);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk_en);

        for (int s = 0; s < 4; s++) begin
            $display("[TB] scenario %0d", s);
            applyStimulus(2'(s), 1'b0, 1'b0);
            handChecks(s);
        end

        $display("[TB] start pulses mid-run and in FIN");
        applyStimulus(2'd0, 1'b1, 1'b1);
        handChecks(0);

        $display("[TB] reset mid-run");
        sel  = 2'd0;
        sbEn = 1'b0;
        @(posedge clk_en); #1 start = 1'b1;
        @(posedge clk_en); #1 start = 1'b0;
        repeat (10) @(posedge clk_en);
        #1;
        checkOutput("midrun_busy_before_reset", int'(mBusy), 1);
        rst_n = 1'b0;
        @(posedge clk_en); #1 rst_n = 1'b1;
        checkAllZero("midreset");
        repeat (3) @(posedge clk_en);
        #1;
        checkOutput("post_reset_idle_conv_on", int'(mConvOn), 0);
        checkOutput("post_reset_idle_busy", int'(mBusy), 0);
        applyStimulus(2'd0, 1'b0, 1'b0);
        handChecks(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at ncyc=%0d expected completion", ncyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
